// File: rtl/pe_dot_seq_if.sv
// ---------------------------------------------------------------------------
// pe_dot_seq_if
// Bundles every signal between the dot-product controller, its
// environment (job source, operand stream, result consumer) and the PE.
//
// Signals:
//   start, len                     job request and number of terms
//   busy                           controller is working on a job
//   in_valid/in_ready/in_row/in_col operand pair stream
//   pe_rst, pe_load_in             PE reset and one-cycle load pulse
//   pe_row_in, pe_col_in           registered operands towards the PE
//   pe_result, pe_done             PE accumulator and per-term done
//   res_valid/res_ready/res_data   dot-product result stream
//   err_timeout                    sticky PE timeout flag
//
// Modports:
//   slave  - the controller (pe_dot_seq)
//   master - everything around it (job source, operand fetch, PE, consumer)
// ---------------------------------------------------------------------------
interface pe_dot_seq_if #(
    parameter int LEN_W = 8,
    parameter int DW    = 32
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_row;
    logic [DW-1:0]    in_col;
    logic             pe_rst;
    logic             pe_load_in;
    logic [DW-1:0]    pe_row_in;
    logic [DW-1:0]    pe_col_in;
    logic [64:0]      pe_result;
    logic             pe_done;
    logic             res_valid;
    logic             res_ready;
    logic [64:0]      res_data;
    logic             err_timeout;

    modport slave (
        input  start, len, in_valid, in_row, in_col, pe_result, pe_done, res_ready,
        output busy, in_ready, pe_rst, pe_load_in, pe_row_in, pe_col_in,
               res_valid, res_data, err_timeout
    );

    modport master (
        output start, len, in_valid, in_row, in_col, pe_result, pe_done, res_ready,
        input  busy, in_ready, pe_rst, pe_load_in, pe_row_in, pe_col_in,
               res_valid, res_data, err_timeout
    );
endinterface

// File: rtl/pe_dot_seq.sv
// ---------------------------------------------------------------------------
// pe_dot_seq
// Sequences one processing element through a len-term dot product:
// clears the PE accumulator, then for every operand pair accepted from the
// input stream it pulses the PE load and waits for the PE done pulse.
// After the final term the PE accumulator is captured and offered on the
// result stream. A PE that stays silent for too long aborts the job into
// ERR, where the PE is held in reset until a new job arrives.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - pe_dot_seq_if.slave (job, operand stream, PE, result stream)
// ---------------------------------------------------------------------------
module pe_dot_seq #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    pe_dot_seq_if.slave     bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        ISSUE,
        WAIT,
        RESULT,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [DW-1:0]    row_q, row_d;
    logic [DW-1:0]    col_q, col_d;
    logic [64:0]      res_q, res_d;
    logic             err_q, err_d;

    // Next-state and datapath updates. Every register holds its value unless
    // the current state says otherwise.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        row_d   = row_q;
        col_d   = col_q;
        res_d   = res_q;
        err_d   = err_q;

        case (state_q)
            IDLE, ERR: begin
                // A zero-length job is ignored, leaving ERR (and its flag)
                // untouched as well.
                if (bus.start && (bus.len != '0)) begin
                    len_d   = bus.len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.in_valid) begin
                    row_d   = bus.in_row;
                    col_d   = bus.in_col;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // pe_done takes priority over a timer expiring in the same
                // cycle. The abort fires when the incremented timer would
                // reach TIMEOUT-1, i.e. TIMEOUT cycles after the load pulse.
                if (bus.pe_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        res_d   = bus.pe_result;
                        state_d = RESULT;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset; a reset
    // in any state drops the job without producing a result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            row_q   <= row_d;
            col_q   <= col_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // The PE only clears on its own reset, so it is reset alongside the
    // controller, for the one CLEAR cycle of each job, and throughout ERR.
    assign bus.pe_rst      = !rst || (state_q == CLEAR) || (state_q == ERR);
    assign bus.busy        = (state_q != IDLE) && (state_q != ERR);
    assign bus.in_ready    = (state_q == FETCH);
    assign bus.pe_load_in  = (state_q == ISSUE);
    assign bus.pe_row_in   = row_q;
    assign bus.pe_col_in   = col_q;
    assign bus.res_valid   = (state_q == RESULT);
    assign bus.res_data    = res_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_pe_dot_seq.sv
// ---------------------------------------------------------------------------
// tb_pe_dot_seq
// Drives pe_dot_seq with directed jobs, models a multiply-accumulate PE
// with configurable latency, and scores each result against the dot product
// queued when the job's operands were chosen.
// ---------------------------------------------------------------------------
module tb_pe_dot_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_dot_seq_if #(.LEN_W(8), .DW(32)) bus ();

    pe_dot_seq #(
        .LEN_W   (8),
        .TIMEOUT (64),
        .DW      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [64:0] exp_q[$];

    int          pe_lat     = 1;
    logic        pe_no_done = 1'b0;

    int          load_cnt   = 0;
    int          prst_cnt   = 0;
    logic        prst_prev  = 1'b0;

    // Behavioural PE: accumulates row*col, reporting done pe_lat cycles after
    // its load; pe_no_done silences it to provoke the controller timeout.
    logic [64:0] pe_acc;
    logic [64:0] pe_prod;
    int          pe_pcnt;
    logic        pe_done_r;

    always @(posedge clk) begin
        if (bus.pe_rst) begin
            pe_acc    <= '0;
            pe_prod   <= '0;
            pe_pcnt   <= 0;
            pe_done_r <= 1'b0;
        end else begin
            pe_done_r <= 1'b0;
            if (bus.pe_load_in) begin
                pe_prod <= 65'(bus.pe_row_in) * 65'(bus.pe_col_in);
                pe_pcnt <= pe_lat;
            end else if (pe_pcnt != 0) begin
                pe_pcnt <= pe_pcnt - 1;
                if ((pe_pcnt == 1) && !pe_no_done) begin
                    pe_acc    <= pe_acc + pe_prod;
                    pe_done_r <= 1'b1;
                end
            end
        end
    end

    assign bus.pe_result = pe_acc;
    assign bus.pe_done   = pe_done_r;

    // Counts PE load pulses and rising edges of pe_rst.
    always @(negedge clk) begin
        if (bus.pe_load_in) load_cnt <= load_cnt + 1;
        if (bus.pe_rst && !prst_prev) prst_cnt <= prst_cnt + 1;
        prst_prev <= bus.pe_rst;
    end

    // Hard stop in case a wait loop is somehow bypassed.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [64:0] observed,
                               input logic [64:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic startJob(input logic [7:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    // Offers one operand pair; once the controller is ready, valid is held
    // low for gap cycles before being raised. Returns in the ISSUE cycle.
    task automatic applyStimulus(input logic [31:0] row, input logic [31:0] col,
                                 input int gap);
        int n = 0;
        while (!bus.in_ready && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) checkOutput("in_ready_wait", 65'(bus.in_ready), 65'd1);
        repeat (gap) tick();
        bus.in_row   = row;
        bus.in_col   = col;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Waits for the result, holds res_ready low for hold cycles checking the
    // result stays put, then completes the handshake and scores the data.
    task automatic getResult(input int hold, input string tag);
        int          n = 0;
        logic [64:0] captured;
        logic [64:0] expected;
        while (!bus.res_valid && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) checkOutput({tag, "_valid_wait"}, 65'(bus.res_valid), 65'd1);
        captured = bus.res_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, 65'(bus.res_valid), 65'd1);
            checkOutput({tag, "_hold_data"}, bus.res_data, captured);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 65'(bus.res_valid), 65'd0);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 65'd1, 65'd0);
        end else begin
            expected = exp_q.pop_front();
            checkOutput(tag, captured, expected);
        end
    endtask

    logic [31:0] ra[255];
    logic [31:0] ca[255];

    initial begin
        int          loads0;
        int          prst0;
        int          n;
        logic        seen_rv;
        logic [64:0] sum;

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.in_col    = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_busy", 65'(bus.busy), 65'd0);
        checkOutput("rst_in_ready", 65'(bus.in_ready), 65'd0);
        checkOutput("rst_load", 65'(bus.pe_load_in), 65'd0);
        checkOutput("rst_res_valid", 65'(bus.res_valid), 65'd0);
        checkOutput("rst_res_data", bus.res_data, 65'd0);
        checkOutput("rst_err", 65'(bus.err_timeout), 65'd0);
        checkOutput("rst_pe_rst", 65'(bus.pe_rst), 65'd1);
        rst = 1'b1;
        tick();
        checkOutput("idle_pe_rst", 65'(bus.pe_rst), 65'd0);

        // Job A: (2,3),(4,5),(6,7)
        loads0 = load_cnt;
        prst0  = prst_cnt;
        exp_q.push_back(65'd68);
        startJob(8'd3);
        checkOutput("a_clear_busy", 65'(bus.busy), 65'd1);
        checkOutput("a_clear_pe_rst", 65'(bus.pe_rst), 65'd1);
        checkOutput("a_clear_no_load", 65'(bus.pe_load_in), 65'd0);
        applyStimulus(32'd2, 32'd3, 0);
        checkOutput("a_issue_load", 65'(bus.pe_load_in), 65'd1);
        checkOutput("a_issue_row", 65'(bus.pe_row_in), 65'd2);
        checkOutput("a_issue_col", 65'(bus.pe_col_in), 65'd3);
        applyStimulus(32'd4, 32'd5, 0);
        applyStimulus(32'd6, 32'd7, 0);
        getResult(0, "job_a");
        checkOutput("a_loads", 65'(load_cnt - loads0), 65'd3);
        checkOutput("a_pe_rst_pulses", 65'(prst_cnt - prst0), 65'd1);
        checkOutput("a_idle_busy", 65'(bus.busy), 65'd0);

        // Job B back-to-back: accumulator must have been cleared
        exp_q.push_back(65'd100);
        startJob(8'd1);
        applyStimulus(32'd10, 32'd10, 0);
        getResult(0, "job_b");

        // Stalls: valid 1-0-0-1, result held with res_ready low 5 cycles
        loads0 = load_cnt;
        exp_q.push_back(65'd68);
        startJob(8'd3);
        applyStimulus(32'd2, 32'd3, 0);
        applyStimulus(32'd4, 32'd5, 2);
        applyStimulus(32'd6, 32'd7, 0);
        getResult(5, "stall");
        checkOutput("stall_loads", 65'(load_cnt - loads0), 65'd3);

        // len=0 is ignored
        loads0 = load_cnt;
        prst0  = prst_cnt;
        startJob(8'd0);
        repeat (4) tick();
        checkOutput("len0_busy", 65'(bus.busy), 65'd0);
        checkOutput("len0_loads", 65'(load_cnt - loads0), 65'd0);
        checkOutput("len0_pe_rst", 65'(prst_cnt - prst0), 65'd0);

        // Timeout: PE never answers
        pe_no_done = 1'b1;
        startJob(8'd1);
        applyStimulus(32'd8, 32'd8, 0);
        checkOutput("to_issue_load", 65'(bus.pe_load_in), 65'd1);
        n = 0;
        while (!bus.err_timeout && n < 200) begin
            tick();
            n++;
        end
        checkOutput("to_cycles", 65'(n), 65'd64);
        checkOutput("to_err_busy", 65'(bus.busy), 65'd0);
        checkOutput("to_err_pe_rst", 65'(bus.pe_rst), 65'd1);
        tick();
        checkOutput("to_err_sticky", 65'(bus.err_timeout), 65'd1);
        startJob(8'd0);
        checkOutput("to_len0_stays_err", 65'(bus.err_timeout), 65'd1);
        pe_no_done = 1'b0;
        exp_q.push_back(65'd9);
        startJob(8'd1);
        checkOutput("to_err_cleared", 65'(bus.err_timeout), 65'd0);
        applyStimulus(32'd3, 32'd3, 0);
        getResult(0, "after_timeout");

        // Maximum length, with two near-full-scale products first
        sum = '0;
        for (int i = 0; i < 255; i++) begin
            ra[i] = (i < 2) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1000));
            ca[i] = (i < 2) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 1000));
            sum   = sum + 65'(ra[i]) * 65'(ca[i]);
        end
        loads0 = load_cnt;
        exp_q.push_back(sum);
        startJob(8'd255);
        for (int i = 0; i < 255; i++) applyStimulus(ra[i], ca[i], 0);
        getResult(0, "max_len");
        checkOutput("max_len_loads", 65'(load_cnt - loads0), 65'd255);

        // Reset during WAIT of term 2 of 3
        pe_lat = 6;
        startJob(8'd3);
        applyStimulus(32'd1, 32'd1, 0);
        applyStimulus(32'd2, 32'd2, 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_pe_rst", 65'(bus.pe_rst), 65'd1);
        tick();
        checkOutput("mid_rst_busy", 65'(bus.busy), 65'd0);
        checkOutput("mid_rst_in_ready", 65'(bus.in_ready), 65'd0);
        checkOutput("mid_rst_load", 65'(bus.pe_load_in), 65'd0);
        checkOutput("mid_rst_row", 65'(bus.pe_row_in), 65'd0);
        checkOutput("mid_rst_col", 65'(bus.pe_col_in), 65'd0);
        checkOutput("mid_rst_res_data", bus.res_data, 65'd0);
        checkOutput("mid_rst_err", 65'(bus.err_timeout), 65'd0);
        rst = 1'b1;
        seen_rv = 1'b0;
        repeat (12) begin
            tick();
            seen_rv = seen_rv | bus.res_valid;
        end
        checkOutput("mid_rst_no_result", 65'(seen_rv), 65'd0);
        pe_lat = 1;
        exp_q.push_back(65'd25);
        startJob(8'd1);
        applyStimulus(32'd5, 32'd5, 0);
        getResult(0, "after_reset");

        checkOutput("scoreboard_drained", 65'(exp_q.size()), 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
